multi_pattern_gen: RTL and testbench
====================================

Name: multi_pattern_gen

Overview:
Parametrised successor to the single-bit `test` data generator that sits behind the PLL.
- Produces CHANNELS independent serial test streams from one clock domain, one bit per bit-tick, MSB first, in WIDTH-bit words.
- Selectable pattern: toggle, counter, PRBS7 or constant.
- Programmable bit-rate divider and a word-frame strobe.
- Sits directly behind the PLL wrapper: clk from the PLL global output, rst from the PLL lock.

Parameters:
WIDTH, 8, bits per serial word (2..32)
CHANNELS, 4, number of parallel output streams (1..16)
DIV, 1, clk cycles per output bit (1..256)

Ports:
clk  input  1  system clock (PLL global output)
rst  input  1  asynchronous active-low reset (PLL LOCK; 0 = reset)
en  input  1  run enable, level-sensitive
mode  input  2  pattern select: 0 toggle, 1 counter, 2 PRBS7, 3 constant
load  input  1  single-cycle pulse: re-latch mode/seed at next word boundary
seed  input  WIDTH  counter start / PRBS seed / constant word
inject  input  1  error-inject pulse (used only with the optional feature)
data  output  CHANNELS  serial bit per channel, registered
frame  output  1  high for exactly the clk cycle in which the first bit (MSB) of a word first appears on data
busy  output  1  high in LOAD and RUN

Behaviour:
- Reset (rst=0, async): state IDLE. data=0, frame=0, busy=0. Prescaler, bit index, counters and LFSRs cleared.
- Release of rst is used directly; the upstream PLL lock is already synchronous to clk.
- FSM states IDLE, LOAD, RUN:
  - IDLE -> LOAD when en=1.
  - LOAD lasts 1 cycle: latch mode and seed, initialise generators, prescaler=0, bit index=0. LOAD -> RUN.
  - RUN -> IDLE in the same cycle en is sampled 0. On that edge: data=0, frame=0, all counters cleared, no partial-word completion.
  - RUN with load pulse: set a pending flag. At the next word boundary (last bit of current word shifted), go to LOAD instead of starting the next word. A load pulse arriving on the boundary cycle itself is honoured at that boundary.
  - load in IDLE/LOAD: ignored (LOAD always latches).
- Timing:
  - en sampled 1 at edge N -> busy=1 from N+1 (LOAD).
  - First MSB on data and frame=1 from edge N+2.
  - Each bit is held DIV clk cycles.
  - Word period = WIDTH*DIV cycles; frame pulses every word period.
- Bit tick: prescaler counts 0..DIV-1 and advances the bit index at DIV-1. DIV=1 gives a tick every cycle.
- Bit index: counts 0..WIDTH-1, then wraps to 0 and loads new words.
- Patterns (channel c = 0..CHANNELS-1):
  - mode 0: word alternates 1,0,1,0... starting with MSB=1, identical on all channels. Odd WIDTH: LSB=1.
  - mode 1: word = (cnt + c) mod 2^WIDTH. cnt starts at seed and increments by 1 per word, wrapping 2^WIDTH-1 -> 0.
  - mode 2: serial PRBS7, x^7+x^6+1, LFSR stepped once per bit tick. Output bit = LFSR[6].
    - Channel c seed = seed[6:0] XOR c[6:0]. An all-zero result is replaced by 7'h7F.
    - WIDTH<7 uses seed zero-extended. Period 127 bits; words are just framing.
  - mode 3: word = seed on all channels.
- Mode and seed changes take effect only through LOAD. Inputs changing during RUN without load have no effect.

Optional Feature:
PATTERN_ERR_INJECT_EN.
- Defined: an inject pulse in RUN arms a one-shot. The next bit emitted on channel 0 (next bit-tick boundary) is inverted for its full DIV cycles. Generator state is unaffected, so only that single bit is wrong. Multiple pulses before that bit collapse into one. Armed flag cleared by reset, IDLE and LOAD.
- Undefined: inject is ignored, no logic generated.

Test Plan:
1. Reset/defaults: hold rst=0 with en=1, mode=1 -> data=0, frame=0, busy=0. Release rst, en=1 at edge N -> busy at N+1, frame at N+2.
2. Counter mode, WIDTH=8, CHANNELS=4, DIV=1, seed=8'hFE:
   - ch0 words FE, FF, 00, 01 (wrap checked).
   - ch3 words 01, 02, 03, 04.
   - frame every 8 cycles.
3. PRBS7, seed=8'h00, CHANNELS=2:
   - ch0 uses 7'h7F, ch1 uses 7'h01.
   - Both sequences repeat after exactly 127 bits and match a reference LFSR model.
4. DIV=3, mode 0, WIDTH=4 -> each channel shows 1,1,1,0,0,0,1,1,1,0,0,0. frame high 1 cycle every 12.
5. Pending load:
   - In RUN (mode 3, seed=8'hA5), pulse load with mode=1, seed=8'h10 mid-word -> current A5 word completes.
   - 1 LOAD cycle follows; next frame starts counter word 8'h10.
   - Dropping en mid-word -> data=0 at next edge.
6. With PATTERN_ERR_INJECT_EN, mode 3, seed=8'hFF: pulse inject -> exactly one ch0 bit reads 0 for DIV cycles. Other channels and later words remain FF.

Source files
------------

// File: rtl/multi_pattern_gen.sv
// multi_pattern_gen: CHANNELS serial test streams (toggle/counter/PRBS7/const).
// Define PATTERN_ERR_INJECT_EN to add the one-shot channel-0 error injector.
module multi_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [WIDTH-1:0]    seed,
  input  logic                inject,
  output logic [CHANNELS-1:0] data,
  output logic                frame,
  output logic                busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [6:0]       lfsr_t;

  function automatic word_t tog_word();
    word_t w;
    for (int i = 0; i < WIDTH; i++) begin
      w[i] = (((WIDTH - 1 - i) % 2) == 0);
    end
    return w;
  endfunction

  localparam word_t TOG = tog_word();

  function automatic word_t gen_word(
    input logic [1:0] m,
    input word_t      s,
    input word_t      cnt,
    input int         c
  );
    word_t w;
    unique case (m)
      2'd0:    w = TOG;
      2'd1:    w = cnt + word_t'(c);
      2'd3:    w = s;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic lfsr_t prbs_init(
    input word_t s,
    input int    c
  );
    lfsr_t v;
    v = 7'(s) ^ 7'(c);
    if (v == '0) v = '1;
    return v;
  endfunction

  function automatic lfsr_t prbs_step(input lfsr_t v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  word_t               seed_q, seed_d;
  logic                pend_q, pend_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [BW-1:0]       bit_q, bit_d;
  word_t               cnt_q, cnt_d;
  word_t               sh_q [CHANNELS];
  word_t               sh_d [CHANNELS];
  lfsr_t               lfsr_q [CHANNELS];
  lfsr_t               lfsr_d [CHANNELS];
  logic [CHANNELS-1:0] data_q, data_d;
  logic                frame_q, frame_d;
  logic                tick;
  logic                last;
  word_t               cnt_n;

`ifdef PATTERN_ERR_INJECT_EN
  logic                arm_q, arm_d;
`else
  logic                unused_inject;
  assign unused_inject = inject;
`endif

  // next-state, generator stepping and serialiser
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    pend_d  = pend_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    frame_d = 1'b0;
    tick    = (pre_q == PW'(DIV - 1));
    last    = (bit_q == BW'(WIDTH - 1));
    cnt_n   = cnt_q + word_t'(1);
`ifdef PATTERN_ERR_INJECT_EN
    arm_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        mode_d  = mode;
        seed_d  = seed;
        cnt_d   = seed;
        pend_d  = 1'b0;
        pre_d   = '0;
        bit_d   = '0;
        frame_d = 1'b1;
        state_d = S_RUN;
        for (int c = 0; c < CHANNELS; c++) begin
          sh_d[c]   = gen_word(mode, seed, seed, c);
          lfsr_d[c] = prbs_init(seed, c);
          data_d[c] = (mode == 2'd2) ? lfsr_d[c][6]
                                     : sh_d[c][WIDTH-1];
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
          pre_d   = '0;
          bit_d   = '0;
          cnt_d   = '0;
          data_d  = '0;
          for (int c = 0; c < CHANNELS; c++) begin
            sh_d[c]   = '0;
            lfsr_d[c] = '0;
          end
        end else begin
          pend_d = pend_q | load;
`ifdef PATTERN_ERR_INJECT_EN
          arm_d  = arm_q | inject;
`endif
          if (!tick) begin
            pre_d = pre_q + PW'(1);
          end else if (last && (pend_q || load)) begin
            state_d = S_LOAD;
            pend_d  = 1'b0;
            pre_d   = '0;
            bit_d   = '0;
            data_d  = '0;
          end else begin
            pre_d   = '0;
            bit_d   = last ? '0 : bit_q + BW'(1);
            frame_d = last;
            if (last) cnt_d = cnt_n;
            for (int c = 0; c < CHANNELS; c++) begin
              sh_d[c]   = last ? gen_word(mode_q, seed_q, cnt_n, c)
                               : word_t'(sh_q[c] << 1);
              lfsr_d[c] = prbs_step(lfsr_q[c]);
              data_d[c] = (mode_q == 2'd2) ? lfsr_d[c][6]
                                           : sh_d[c][WIDTH-1];
            end
`ifdef PATTERN_ERR_INJECT_EN
            if (arm_q) begin
              data_d[0] = ~data_d[0];
              arm_d     = 1'b0;
            end
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      seed_q  <= '0;
      pend_q  <= 1'b0;
      pre_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      frame_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        sh_q[c]   <= '0;
        lfsr_q[c] <= '0;
      end
`ifdef PATTERN_ERR_INJECT_EN
      arm_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      pend_q  <= pend_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      sh_q    <= sh_d;
      lfsr_q  <= lfsr_d;
`ifdef PATTERN_ERR_INJECT_EN
      arm_q   <= arm_d;
`endif
    end
  end

  assign data  = data_q;
  assign frame = frame_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_pattern_gen.sv
// tb_multi_pattern_gen: randomized bench with a stream-level reference model.
// Two instances: 8b/4ch/DIV1 and 4b/2ch/DIV3.
module tb_multi_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, load0, inject0;
  logic [1:0] mode0;
  logic [7:0] seed0;
  logic [3:0] data0;
  logic       frame0, busy0;
  logic       en1, load1, inject1;
  logic [1:0] mode1;
  logic [3:0] seed1;
  logic [1:0] data1;
  logic       frame1, busy1;

  int checks;
  int errors;

  always #5 clk = ~clk;

  multi_pattern_gen #(.WIDTH(8), .CHANNELS(4), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .en(en0), .mode(mode0),
    .load(load0), .seed(seed0), .inject(inject0),
    .data(data0), .frame(frame0), .busy(busy0)
  );

  multi_pattern_gen #(.WIDTH(4), .CHANNELS(2), .DIV(3)) u1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1),
    .load(load1), .seed(seed1), .inject(inject1),
    .data(data1), .frame(frame1), .busy(busy1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // PRBS7 as a bit recurrence: o[n+7] = o[n] ^ o[n+1]
  function automatic bit prbs_bit(input int s, input int c, input int b);
    bit o [0:511];
    int s7;
    s7 = (s ^ c) & 127;
    if (s7 == 0) s7 = 127;
    for (int j = 0; j < 7; j++) o[j] = ((s7 >> (6 - j)) & 1) != 0;
    for (int n = 7; n <= b; n++) o[n] = o[n-7] ^ o[n-6];
    return o[b];
  endfunction

  // expected bit on channel c, k cycles after the first MSB
  function automatic bit exp_bit(input int w, input int d, input int m,
                                 input int s, input int c, input int k);
    int b, wd, pos, i, mask;
    b    = k / d;
    wd   = b / w;
    pos  = b % w;
    i    = w - 1 - pos;
    mask = (1 << w) - 1;
    case (m)
      0:       return (pos % 2) == 0;
      1:       return ((((s + wd + c) & mask) >> i) & 1) != 0;
      2:       return prbs_bit(s, c, b);
      default: return ((s >> i) & 1) != 0;
    endcase
  endfunction

  task automatic drive(input int u, input logic e, input logic [1:0] m,
                       input logic [7:0] s, input logic ld,
                       input logic ij);
    if (u == 0) begin
      en0 = e; mode0 = m; seed0 = s; load0 = ld; inject0 = ij;
    end else begin
      en1 = e; mode1 = m; seed1 = s[3:0]; load1 = ld; inject1 = ij;
    end
  endtask

  function automatic logic [3:0] get_data(input int u);
    return (u == 0) ? data0 : {2'b00, data1};
  endfunction

  function automatic logic get_frame(input int u);
    return (u == 0) ? frame0 : frame1;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  task automatic run(input int u, input int m, input int s,
                     input int ncyc);
    int w, d, n;
    logic [3:0] ev;
    w = (u == 0) ? 8 : 4;
    d = (u == 0) ? 1 : 3;
    n = (u == 0) ? 4 : 2;
    @(negedge clk);
    rst = 1'b1;
    drive(u, 1'b1, 2'(m), 8'(s), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("busy_load_u%0d", u), 32'(get_busy(u)), 1);
    check($sformatf("frame_load_u%0d", u), 32'(get_frame(u)), 0);
    check($sformatf("data_load_u%0d", u), 32'(get_data(u)), 0);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      ev = '0;
      for (int c = 0; c < n; c++) ev[c] = exp_bit(w, d, m, s, c, k);
      check($sformatf("data_u%0d_m%0d_k%0d", u, m, k),
            32'(get_data(u)), 32'(ev));
      check($sformatf("frame_u%0d_k%0d", u, k),
            32'(get_frame(u)), 32'((k % (w * d)) == 0));
      check($sformatf("busy_u%0d_k%0d", u, k), 32'(get_busy(u)), 1);
    end
    drive(u, 1'b0, 2'(m), 8'(s), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("data_stop_u%0d", u), 32'(get_data(u)), 0);
    check($sformatf("frame_stop_u%0d", u), 32'(get_frame(u)), 0);
    check($sformatf("busy_stop_u%0d", u), 32'(get_busy(u)), 0);
  endtask

  task automatic pend_test();
    logic [3:0] ev;
    logic       ef;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 2'd3, 8'hA5, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pend_busy_load", 32'(busy0), 1);
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      ev = '0;
      ef = 1'b0;
      if (k < 8) begin
        for (int c = 0; c < 4; c++) ev[c] = ((8'hA5 >> (7 - k)) & 1) != 0;
        ef = (k == 0);
      end else if (k >= 9 && k <= 16) begin
        for (int c = 0; c < 4; c++)
          ev[c] = (((8'h10 + c) >> (7 - (k - 9))) & 1) != 0;
        ef = (k == 9);
      end else if (k >= 18) begin
        for (int c = 0; c < 4; c++)
          ev[c] = ((8'h3C >> (7 - (k - 18))) & 1) != 0;
        ef = (k == 18);
      end
      check($sformatf("pend_data_k%0d", k), 32'(data0), 32'(ev));
      check($sformatf("pend_frame_k%0d", k), 32'(frame0), 32'(ef));
      check($sformatf("pend_busy_k%0d", k), 32'(busy0), 1);
      if (k == 3)       drive(0, 1'b1, 2'd1, 8'h10, 1'b1, 1'b0);
      else if (k == 11) drive(0, 1'b1, 2'd0, 8'h77, 1'b0, 1'b0);
      else if (k == 16) drive(0, 1'b1, 2'd3, 8'h3C, 1'b1, 1'b0);
      else if (k == 19) drive(0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0);
      else if (k == 20) drive(0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
      else              load0 = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("pend_data_stop", 32'(data0), 0);
    check("pend_frame_stop", 32'(frame0), 0);
    check("pend_busy_stop", 32'(busy0), 0);
  endtask

  task automatic async_rst_test();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("arst_pre_data", 32'(data0), 32'hF);
    rst = 1'b0;
    #1;
    check("arst_data", 32'(data0), 0);
    check("arst_busy", 32'(busy0), 0);
    check("arst_frame", 32'(frame0), 0);
    drive(0, 1'b0, 2'd3, 8'hFF, 1'b0, 1'b0);
  endtask

`ifdef PATTERN_ERR_INJECT_EN
  task automatic inj_test(input int u);
    int d, n, z0, zo, first, lst;
    logic [3:0] dv;
    d     = (u == 0) ? 1 : 3;
    n     = (u == 0) ? 4 : 2;
    z0    = 0;
    zo    = 0;
    first = -1;
    lst   = -2;
    @(negedge clk);
    rst = 1'b1;
    drive(u, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 36; k++) begin
      @(posedge clk);
      @(negedge clk);
      dv = get_data(u);
      if (!dv[0]) begin
        z0++;
        if (first < 0) first = k;
        lst = k;
      end
      for (int c = 1; c < n; c++) if (!dv[c]) zo++;
      drive(u, 1'b1, 2'd3, 8'hFF, 1'b0,
            (k == 4) || (u == 1 && k == 5));
    end
    check($sformatf("inj_zeros_u%0d", u), 32'(z0), 32'(d));
    check($sformatf("inj_other_u%0d", u), 32'(zo), 0);
    check($sformatf("inj_span_u%0d", u), 32'(lst - first + 1), 32'(d));
    drive(u, 1'b0, 2'd3, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog expired got=running exp=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst    = 1'b0;
    checks = 0;
    errors = 0;
    drive(0, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b0);
    drive(1, 1'b1, 2'd1, 8'h05, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_data0", 32'(data0), 0);
    check("rst_frame0", 32'(frame0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_data1", 32'(data1), 0);
    check("rst_busy1", 32'(busy1), 0);
    drive(1, 1'b0, 2'd1, 8'h05, 1'b0, 1'b0);

    run(0, 1, 8'hFE, 40);
    for (int i = 0; i < 3; i++)
      run(0, 1, int'($urandom_range(0, 255)),
          20 + int'($urandom_range(0, 10)));
    run(0, 2, 8'h00, 136);
    run(0, 2, 8'h83, 60);
    for (int i = 0; i < 2; i++)
      run(0, 2, int'($urandom_range(0, 255)), 140);
    run(0, 0, int'($urandom_range(0, 255)), 24);
    for (int i = 0; i < 2; i++)
      run(0, 3, int'($urandom_range(0, 255)), 20);

    run(1, 0, 0, 36);
    run(1, 1, int'($urandom_range(0, 15)), 50);
    run(1, 2, 1, 60);
    run(1, 2, int'($urandom_range(0, 15)), 60);
    run(1, 3, int'($urandom_range(0, 15)), 26);

    pend_test();
    async_rst_test();
`ifdef PATTERN_ERR_INJECT_EN
    inj_test(0);
    inj_test(1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
